// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - request, ALU and result signals of alu_issue_ctrl
// Ports (modport master = issue controller, slave = its environment):
//   request : in_valid/in_ready, in_op, in_funct, in_shamt, in_imm, in_rs, in_rt
//   alu     : alu_a, alu_b, alu_aluc out; alu_r, alu_zero/carry/negative/overflow in
//   result  : out_valid/out_ready, out_result, out_flags, out_hi, out_lo,
//             out_hilo_we, out_illegal, out_trap
interface alu_issue_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int ALUC_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        in_op;
    logic [5:0]        in_funct;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic [XLEN-1:0]   in_rs;
    logic [XLEN-1:0]   in_rt;
    logic [XLEN-1:0]   alu_a;
    logic [XLEN-1:0]   alu_b;
    logic [ALUC_W-1:0] alu_aluc;
    logic [XLEN-1:0]   alu_r;
    logic              alu_zero;
    logic              alu_carry;
    logic              alu_negative;
    logic              alu_overflow;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_result;
    logic [3:0]        out_flags;
    logic [XLEN-1:0]   out_hi;
    logic [XLEN-1:0]   out_lo;
    logic              out_hilo_we;
    logic              out_illegal;
    logic              out_trap;

    modport master (
        input  in_valid, in_op, in_funct, in_shamt, in_imm, in_rs, in_rt,
        input  alu_r, alu_zero, alu_carry, alu_negative, alu_overflow,
        input  out_ready,
        output in_ready, alu_a, alu_b, alu_aluc,
        output out_valid, out_result, out_flags, out_hi, out_lo,
        output out_hilo_we, out_illegal, out_trap
    );

    modport slave (
        output in_valid, in_op, in_funct, in_shamt, in_imm, in_rs, in_rt,
        output alu_r, alu_zero, alu_carry, alu_negative, alu_overflow,
        output out_ready,
        input  in_ready, alu_a, alu_b, alu_aluc,
        input  out_valid, out_result, out_flags, out_hi, out_lo,
        input  out_hilo_we, out_illegal, out_trap
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - MIPS ALU issue controller with iterative MULTU/DIVU
// Ports: clk, rst_n (async active-low), bus (alu_issue_ctrl_if.master).
// Optional: define ALU_TRAP_EN to raise out_trap on signed overflow of add/addi/sub.
module alu_issue_ctrl #(
    parameter int XLEN   = 32,
    parameter int ALUC_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.master  bus
);
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_OUT} state_t;

    state_t            state_q;
    logic              in_ready_q;
    logic [XLEN-1:0]   alu_a_q, alu_b_q;
    logic [ALUC_W-1:0] aluc_q;
    logic              illegal_q;
    logic [XLEN-1:0]   hi_q, lo_q, mcand_q;
    logic [4:0]        cnt_q;
    logic              out_valid_q, out_hilo_we_q, out_illegal_q;
    logic [XLEN-1:0]   out_result_q, out_hi_q, out_lo_q;
    logic [3:0]        out_flags_q;

    logic              dec_legal, dec_mul, dec_div;
    logic [ALUC_W-1:0] dec_aluc;
    logic [XLEN-1:0]   dec_a, dec_b;
    logic              accept;

    always_comb begin
        dec_legal = 1'b1;
        dec_mul   = 1'b0;
        dec_div   = 1'b0;
        dec_aluc  = '0;
        dec_a     = bus.in_rs;
        dec_b     = bus.in_rt;
        if (bus.in_op == 6'h00) begin
            case (bus.in_funct)
                6'h20: dec_aluc = 6'b000010;
                6'h21: dec_aluc = 6'b000000;
                6'h22: dec_aluc = 6'b000011;
                6'h23: dec_aluc = 6'b000001;
                6'h24: dec_aluc = 6'b000100;
                6'h25: dec_aluc = 6'b000101;
                6'h26: dec_aluc = 6'b000110;
                6'h27: dec_aluc = 6'b000111;
                6'h2A: dec_aluc = 6'b001011;
                6'h2B: dec_aluc = 6'b001010;
                6'h00: begin dec_aluc = 6'b001110; dec_a = {{(XLEN-5){1'b0}}, bus.in_shamt}; end
                6'h02: begin dec_aluc = 6'b001101; dec_a = {{(XLEN-5){1'b0}}, bus.in_shamt}; end
                6'h03: begin dec_aluc = 6'b001100; dec_a = {{(XLEN-5){1'b0}}, bus.in_shamt}; end
                6'h04: begin dec_aluc = 6'b001110; dec_a = {{(XLEN-5){1'b0}}, bus.in_rs[4:0]}; end
                6'h06: begin dec_aluc = 6'b001101; dec_a = {{(XLEN-5){1'b0}}, bus.in_rs[4:0]}; end
                6'h07: begin dec_aluc = 6'b001100; dec_a = {{(XLEN-5){1'b0}}, bus.in_rs[4:0]}; end
                6'h19: begin dec_aluc = 6'b010001; dec_mul = 1'b1; end
                6'h1B: begin dec_aluc = 6'b010000; dec_div = 1'b1; end
                default: dec_legal = 1'b0;
            endcase
        end else begin
            case (bus.in_op)
                6'h08: begin dec_aluc = 6'b000010; dec_b = {{(XLEN-16){bus.in_imm[15]}}, bus.in_imm}; end
                6'h09: begin dec_aluc = 6'b000000; dec_b = {{(XLEN-16){bus.in_imm[15]}}, bus.in_imm}; end
                6'h0A: begin dec_aluc = 6'b001011; dec_b = {{(XLEN-16){bus.in_imm[15]}}, bus.in_imm}; end
                6'h0B: begin dec_aluc = 6'b001010; dec_b = {{(XLEN-16){bus.in_imm[15]}}, bus.in_imm}; end
                6'h0C: begin dec_aluc = 6'b000100; dec_b = {{(XLEN-16){1'b0}}, bus.in_imm}; end
                6'h0D: begin dec_aluc = 6'b000101; dec_b = {{(XLEN-16){1'b0}}, bus.in_imm}; end
                6'h0E: begin dec_aluc = 6'b000110; dec_b = {{(XLEN-16){1'b0}}, bus.in_imm}; end
                6'h0F: begin dec_aluc = 6'b001000; dec_b = {{(XLEN-16){1'b0}}, bus.in_imm}; dec_a = '0; end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    assign accept = in_ready_q & bus.in_valid;

    // Shift-add step: {hi,lo} holds {partial sum, remaining multiplier bits}.
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_nx, mul_lo_nx;
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_hi_nx = mul_sum[XLEN:1];
    assign mul_lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};

    // Restoring step: hi = partial remainder, lo = dividend shifting into quotient.
    // A zero divisor always "fits", giving an all-ones quotient and remainder = rs.
    logic [XLEN:0]   div_sh;
    logic            div_ge;
    logic [XLEN-1:0] div_hi_nx, div_lo_nx;
    assign div_sh    = {hi_q, lo_q[XLEN-1]};
    assign div_ge    = div_sh >= {1'b0, mcand_q};
    assign div_hi_nx = div_ge ? (div_sh[XLEN-1:0] - mcand_q) : div_sh[XLEN-1:0];
    assign div_lo_nx = {lo_q[XLEN-2:0], div_ge};

`ifdef ALU_TRAP_EN
    logic trap_op_q, trap_sub_q, out_trap_q;
    logic dec_trap_op, dec_sub, ovf;
    assign dec_sub     = (bus.in_op == 6'h00) && (bus.in_funct == 6'h22);
    assign dec_trap_op = ((bus.in_op == 6'h00) && (bus.in_funct == 6'h20)) || dec_sub
                         || (bus.in_op == 6'h08);
    assign ovf = (alu_a_q[XLEN-1] == (alu_b_q[XLEN-1] ^ trap_sub_q))
                 && (bus.alu_r[XLEN-1] != alu_a_q[XLEN-1]);
    assign bus.out_trap = out_trap_q;
`else
    assign bus.out_trap = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            aluc_q        <= '0;
            illegal_q     <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            mcand_q       <= '0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_hilo_we_q <= 1'b0;
            out_illegal_q <= 1'b0;
            out_result_q  <= '0;
            out_hi_q      <= '0;
            out_lo_q      <= '0;
            out_flags_q   <= '0;
`ifdef ALU_TRAP_EN
            trap_op_q     <= 1'b0;
            trap_sub_q    <= 1'b0;
            out_trap_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        illegal_q  <= ~dec_legal;
                        cnt_q      <= '0;
                        // Illegal requests leave the ALU ports as they were.
                        if (dec_legal) begin
                            alu_a_q <= dec_a;
                            alu_b_q <= dec_b;
                            aluc_q  <= dec_aluc;
                        end
`ifdef ALU_TRAP_EN
                        trap_op_q  <= dec_trap_op;
                        trap_sub_q <= dec_sub;
`endif
                        if (dec_mul) begin
                            hi_q <= '0; lo_q <= bus.in_rt; mcand_q <= bus.in_rs;
                            state_q <= S_MUL;
                        end else if (dec_div) begin
                            hi_q <= '0; lo_q <= bus.in_rs; mcand_q <= bus.in_rt;
                            state_q <= S_DIV;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end else begin
                        // Also raises ready on the first edge after reset release.
                        in_ready_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    out_valid_q   <= 1'b1;
                    out_hilo_we_q <= 1'b0;
                    out_hi_q      <= '0;
                    out_lo_q      <= '0;
                    out_illegal_q <= illegal_q;
                    if (illegal_q) begin
                        out_result_q <= '0;
                        out_flags_q  <= '0;
                    end else begin
                        out_result_q <= bus.alu_r;
                        out_flags_q  <= {bus.alu_overflow, bus.alu_negative,
                                         bus.alu_carry, bus.alu_zero};
                    end
`ifdef ALU_TRAP_EN
                    out_trap_q <= ~illegal_q & trap_op_q & ovf;
`endif
                    state_q <= S_OUT;
                end
                S_MUL, S_DIV: begin
                    hi_q  <= (state_q == S_MUL) ? mul_hi_nx : div_hi_nx;
                    lo_q  <= (state_q == S_MUL) ? mul_lo_nx : div_lo_nx;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        out_valid_q   <= 1'b1;
                        out_hilo_we_q <= 1'b1;
                        out_illegal_q <= 1'b0;
                        out_flags_q   <= '0;
                        out_hi_q      <= (state_q == S_MUL) ? mul_hi_nx : div_hi_nx;
                        out_lo_q      <= (state_q == S_MUL) ? mul_lo_nx : div_lo_nx;
                        out_result_q  <= (state_q == S_MUL) ? mul_lo_nx : div_lo_nx;
                        state_q       <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
`ifdef ALU_TRAP_EN
                        out_trap_q  <= 1'b0;
`endif
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_aluc    = aluc_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_flags   = out_flags_q;
    assign bus.out_hi      = out_hi_q;
    assign bus.out_lo      = out_lo_q;
    assign bus.out_hilo_we = out_hilo_we_q;
    assign bus.out_illegal = out_illegal_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed vector bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_issue_ctrl_if u_if ();

    alu_issue_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

`ifdef ALU_TRAP_EN
    localparam logic TRAP_EXP = 1'b1;
`else
    localparam logic TRAP_EXP = 1'b0;
`endif

    // Reference ALU: the block only drives it, so the bench has to supply one.
    logic [31:0] m_r;
    logic [32:0] m_s;
    logic        m_c, m_v;
    always_comb begin
        m_r = '0; m_s = '0; m_c = 1'b0; m_v = 1'b0;
        case (u_if.alu_aluc)
            6'h00, 6'h02: begin
                m_s = {1'b0, u_if.alu_a} + {1'b0, u_if.alu_b};
                m_r = m_s[31:0];
                m_c = m_s[32];
                if (u_if.alu_aluc == 6'h02)
                    m_v = (u_if.alu_a[31] == u_if.alu_b[31]) && (m_r[31] != u_if.alu_a[31]);
            end
            6'h01, 6'h03: begin
                m_r = u_if.alu_a - u_if.alu_b;
                m_c = u_if.alu_a < u_if.alu_b;
                if (u_if.alu_aluc == 6'h03)
                    m_v = (u_if.alu_a[31] != u_if.alu_b[31]) && (m_r[31] != u_if.alu_a[31]);
            end
            6'h04: m_r = u_if.alu_a & u_if.alu_b;
            6'h05: m_r = u_if.alu_a | u_if.alu_b;
            6'h06: m_r = u_if.alu_a ^ u_if.alu_b;
            6'h07: m_r = ~(u_if.alu_a | u_if.alu_b);
            6'h0B: m_r = {31'b0, $signed(u_if.alu_a) < $signed(u_if.alu_b)};
            6'h0A: m_r = {31'b0, u_if.alu_a < u_if.alu_b};
            6'h0E: m_r = u_if.alu_b << u_if.alu_a[4:0];
            6'h0D: m_r = u_if.alu_b >> u_if.alu_a[4:0];
            6'h0C: m_r = $unsigned($signed(u_if.alu_b) >>> u_if.alu_a[4:0]);
            6'h08: m_r = {u_if.alu_b[15:0], 16'h0000};
            default: m_r = '0;
        endcase
    end
    assign u_if.alu_r        = m_r;
    assign u_if.alu_zero     = (m_r == 32'h0);
    assign u_if.alu_carry    = m_c;
    assign u_if.alu_negative = m_r[31];
    assign u_if.alu_overflow = m_v;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [5:0]  aluc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
        logic        hilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ill;
        logic        trap;
        int          lat;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        int k;
        int lat;
        k = 0;
        while (!u_if.in_ready && k < 50) begin @(posedge clk); #1; k++; end
        chk({tag, ".in_ready"}, u_if.in_ready, 1);
        u_if.in_valid = 1'b1;
        u_if.in_op    = v.op;
        u_if.in_funct = v.funct;
        u_if.in_shamt = v.shamt;
        u_if.in_imm   = v.imm;
        u_if.in_rs    = v.rs;
        u_if.in_rt    = v.rt;
        @(posedge clk); #1;
        u_if.in_valid = 1'b0;
        chk({tag, ".busy"}, u_if.in_ready, 0);
        chk({tag, ".aluc"}, u_if.alu_aluc, v.aluc);
        chk({tag, ".a"}, u_if.alu_a, v.a);
        chk({tag, ".b"}, u_if.alu_b, v.b);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (u_if.out_valid) begin lat = i; break; end
        end
        chk({tag, ".latency"}, lat, v.lat);
        chk({tag, ".result"}, u_if.out_result, v.res);
        chk({tag, ".flags"}, u_if.out_flags, v.flags);
        chk({tag, ".hilo_we"}, u_if.out_hilo_we, v.hilo);
        chk({tag, ".illegal"}, u_if.out_illegal, v.ill);
        chk({tag, ".trap"}, u_if.out_trap, v.trap);
        if (v.hilo) begin
            chk({tag, ".hi"}, u_if.out_hi, v.hi);
            chk({tag, ".lo"}, u_if.out_lo, v.lo);
        end
        u_if.out_ready = 1'b1;
        @(posedge clk); #1;
        u_if.out_ready = 1'b0;
        chk({tag, ".valid_drop"}, u_if.out_valid, 0);
        chk({tag, ".ready_back"}, u_if.in_ready, 1);
        chk({tag, ".trap_clr"}, u_if.out_trap, 0);
    endtask

    vec_t tbl[17];
    vec_t bp;
    logic seen;

    initial begin
        //          op     funct  sh  imm       rs            rt            aluc   a             b             res           flags hilo hi         lo            ill trap      lat
        tbl[0]  = '{6'h00, 6'h21, 0, 16'h0,    32'h5,        32'h3,        6'h00, 32'h5,        32'h3,        32'h8,        4'h0, 0, 32'h0,      32'h0,        0, 0,        1};
        tbl[1]  = '{6'h00, 6'h03, 4, 16'h0,    32'h12345678, 32'h80000000, 6'h0C, 32'h4,        32'h80000000, 32'hF8000000, 4'h4, 0, 32'h0,      32'h0,        0, 0,        1};
        tbl[2]  = '{6'h00, 6'h22, 0, 16'h0,    32'h5,        32'h5,        6'h03, 32'h5,        32'h5,        32'h0,        4'h1, 0, 32'h0,      32'h0,        0, 0,        1};
        tbl[3]  = '{6'h00, 6'h2A, 0, 16'h0,    32'hFFFFFFFF, 32'h1,        6'h0B, 32'hFFFFFFFF, 32'h1,        32'h1,        4'h0, 0, 32'h0,      32'h0,        0, 0,        1};
        tbl[4]  = '{6'h00, 6'h04, 0, 16'h0,    32'h24,       32'h1,        6'h0E, 32'h4,        32'h1,        32'h10,       4'h0, 0, 32'h0,      32'h0,        0, 0,        1};
        tbl[5]  = '{6'h0F, 6'h00, 0, 16'hABCD, 32'h55,       32'h0,        6'h08, 32'h0,        32'h0000ABCD, 32'hABCD0000, 4'h4, 0, 32'h0,      32'h0,        0, 0,        1};
        tbl[6]  = '{6'h08, 6'h00, 0, 16'hFFFF, 32'h1,        32'h0,        6'h02, 32'h1,        32'hFFFFFFFF, 32'h0,        4'h3, 0, 32'h0,      32'h0,        0, 0,        1};
        tbl[7]  = '{6'h0C, 6'h00, 0, 16'h8F0F, 32'hFFFF00FF, 32'h0,        6'h04, 32'hFFFF00FF, 32'h00008F0F, 32'h0000000F, 4'h0, 0, 32'h0,      32'h0,        0, 0,        1};
        tbl[8]  = '{6'h00, 6'h19, 0, 16'h0,    32'hFFFFFFFF, 32'h2,        6'h11, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 4'h0, 1, 32'h1,      32'hFFFFFFFE, 0, 0,        32};
        tbl[9]  = '{6'h00, 6'h1B, 0, 16'h0,    32'd100,      32'd7,        6'h10, 32'd100,      32'd7,        32'd14,       4'h0, 1, 32'd2,      32'd14,       0, 0,        32};
        tbl[10] = '{6'h00, 6'h1B, 0, 16'h0,    32'h1234,     32'h0,        6'h10, 32'h1234,     32'h0,        32'hFFFFFFFF, 4'h0, 1, 32'h1234,   32'hFFFFFFFF, 0, 0,        32};
        tbl[11] = '{6'h3F, 6'h00, 0, 16'h0,    32'hDEAD,     32'hBEEF,     6'h10, 32'h1234,     32'h0,        32'h0,        4'h0, 0, 32'h0,      32'h0,        1, 0,        1};
        tbl[12] = '{6'h00, 6'h01, 0, 16'h0,    32'h77,       32'h88,       6'h10, 32'h1234,     32'h0,        32'h0,        4'h0, 0, 32'h0,      32'h0,        1, 0,        1};
        tbl[13] = '{6'h0E, 6'h00, 0, 16'h00FF, 32'h0F0F,     32'h0,        6'h06, 32'h0F0F,     32'h00FF,     32'h0FF0,     4'h0, 0, 32'h0,      32'h0,        0, 0,        1};
        tbl[14] = '{6'h00, 6'h27, 0, 16'h0,    32'h0,        32'h0,        6'h07, 32'h0,        32'h0,        32'hFFFFFFFF, 4'h4, 0, 32'h0,      32'h0,        0, 0,        1};
        tbl[15] = '{6'h00, 6'h20, 0, 16'h0,    32'h7FFFFFFF, 32'h1,        6'h02, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'hC, 0, 32'h0,      32'h0,        0, TRAP_EXP, 1};
        tbl[16] = '{6'h00, 6'h21, 0, 16'h0,    32'h7FFFFFFF, 32'h1,        6'h00, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'h4, 0, 32'h0,      32'h0,        0, 0,        1};

        rst_n = 1'b0;
        u_if.in_valid = 1'b0; u_if.out_ready = 1'b0;
        u_if.in_op = '0; u_if.in_funct = '0; u_if.in_shamt = '0;
        u_if.in_imm = '0; u_if.in_rs = '0; u_if.in_rt = '0;
        #3;
        chk("reset.out_valid", u_if.out_valid, 0);
        chk("reset.in_ready", u_if.in_ready, 0);
        chk("reset.result", u_if.out_result, 0);
        chk("reset.aluc", u_if.alu_aluc, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("release.in_ready_low", u_if.in_ready, 0);
        @(posedge clk); #1;
        chk("release.in_ready_high", u_if.in_ready, 1);

        for (int i = 0; i < 17; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Backpressure: result must hold while out_ready stays low.
        u_if.in_valid = 1'b1; u_if.in_op = 6'h00; u_if.in_funct = 6'h21;
        u_if.in_rs = 32'd10; u_if.in_rt = 32'd20;
        @(posedge clk); #1 u_if.in_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", u_if.out_valid, 1);
            chk("bp.result", u_if.out_result, 32'd30);
            chk("bp.in_ready", u_if.in_ready, 0);
            @(posedge clk); #1;
        end
        u_if.out_ready = 1'b1;
        @(posedge clk); #1 u_if.out_ready = 1'b0;
        chk("bp.release", u_if.out_valid, 0);

        // Reset in the middle of a DIVU discards it.
        u_if.in_valid = 1'b1; u_if.in_funct = 6'h1B;
        u_if.in_rs = 32'd100; u_if.in_rt = 32'd7;
        @(posedge clk); #1 u_if.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        chk("midrst.valid", u_if.out_valid, 0);
        chk("midrst.in_ready", u_if.in_ready, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        u_if.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("midrst.ready_after", u_if.in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (u_if.out_valid) seen = 1'b1;
        end
        u_if.out_ready = 1'b0;
        chk("midrst.no_result", seen, 0);

        bp = tbl[9];
        run(bp, "post_rst_divu");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU port: accepts a decoded MIPS instruction's fields and operand values over a valid/ready handshake.
- Selects ALU operands and the 6-bit aluc code, drives the combinational ALU, registers its result and flags, and returns them over a second valid/ready handshake.
- MULTU/DIVU do not use the ALU; they run iteratively in-block (32 cycles) and produce HI/LO.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- ALUC_W, 6, width of the ALU control code.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction request.
- in_ready  out  1  block can accept a request.
- in_op  in  6  opcode.
- in_funct  in  6  funct field (R-type).
- in_shamt  in  5  shift amount.
- in_imm  in  16  immediate.
- in_rs  in  32  rs value.
- in_rt  in  32  rt value.
- alu_a  out  32  ALU operand a (shift amount for shifts).
- alu_b  out  32  ALU operand b.
- alu_aluc  out  6  ALU control code.
- alu_r  in  32  ALU result.
- alu_zero, alu_carry, alu_negative, alu_overflow  in  1 each  ALU flags.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  32  ALU result, or LO for MULTU/DIVU.
- out_flags  out  4  {overflow, negative, carry, zero}.
- out_hi, out_lo  out  32 each  HI/LO for MULTU/DIVU.
- out_hilo_we  out  1  out_hi/out_lo valid.
- out_illegal  out  1  undecodable instruction.
- out_trap  out  1  signed overflow trap (see Optional Feature).

Behaviour:
- Reset: all outputs 0 and state IDLE; any in-flight operation is discarded. in_ready is 0 while rst_n is low and 1 on the first cycle after release.
- States:
  - IDLE: in_ready=1.
  - EXEC: one cycle.
  - MUL and DIV: 32 cycles each.
  - OUT: hold until out_ready.
  - in_ready=1 only in IDLE.
- Accept edge N (in_valid & in_ready): decode and register alu_a/alu_b/alu_aluc; they stay stable until the next accept.
  - Legal ALU op: EXEC, then at N+1 capture alu_r and the flags, go to OUT; out_valid=1 from N+1.
  - MULTU/DIVU: iterate on edges N+1..N+32; out_valid=1 from N+32.
  - Illegal: go directly to OUT at N+1 with out_illegal=1 and result/flags 0.
- OUT: outputs are held while out_ready=0. Handshake edge → IDLE and out_valid=0. The next accept is possible on the following edge (throughput of 1 op per 3 cycles for ALU ops).
- R-type decode (op=0x00):

| funct | instruction | alu_aluc | alu_a | alu_b |
|---|---|---|---|---|
| 20 | add | 0010 | rs | rt |
| 21 | addu | 0000 | rs | rt |
| 22 | sub | 0011 | rs | rt |
| 23 | subu | 0001 | rs | rt |
| 24 | and | 0100 | rs | rt |
| 25 | or | 0101 | rs | rt |
| 26 | xor | 0110 | rs | rt |
| 27 | nor | 0111 | rs | rt |
| 2A | slt | 1011 | rs | rt |
| 2B | sltu | 1010 | rs | rt |
| 00 | sll | 1110 | zext shamt | rt |
| 02 | srl | 1101 | zext shamt | rt |
| 03 | sra | 1100 | zext shamt | rt |
| 04 | sllv | 1110 | {27'b0, rs[4:0]} | rt |
| 06 | srlv | 1101 | {27'b0, rs[4:0]} | rt |
| 07 | srav | 1100 | {27'b0, rs[4:0]} | rt |
| 19 | multu | 010001 | rs | rt |
| 1B | divu | 010000 | rs | rt |

  - The 4-bit codes above are zero-extended to 6 bits.
- I-type decode (alu_a=rs unless noted):

| op | instruction | alu_aluc | alu_b |
|---|---|---|---|
| 08 | addi | 0010 | sext imm |
| 09 | addiu | 0000 | sext imm |
| 0A | slti | 1011 | sext imm |
| 0B | sltiu | 1010 | sext imm |
| 0C | andi | 0100 | zext imm |
| 0D | ori | 0101 | zext imm |
| 0E | xori | 0110 | zext imm |
| 0F | lui | 1000 | zext imm; alu_a=0 |

  - Anything else is illegal.
- MULTU: shift-add, 64-bit unsigned product. out_hi = high 32 bits, out_lo = out_result = low 32 bits.
- DIVU: radix-2 restoring division, out_lo = quotient, out_hi = remainder.
  - rt=0 needs no special path and has unchanged latency: lo=FFFFFFFF, hi=rs.
- MULTU/DIVU result flags: out_flags=0, out_hilo_we=1. All other ops: out_hilo_we=0.
- Flags are passed through from the ALU unmodified.

Optional Feature:
- ALU_TRAP_EN defined: for add/addi/sub only, out_trap=1 when the locally computed signed overflow is set.
  - Overflow rule: operands of equal sign (b inverted for sub) and result sign differs from a.
  - out_trap is registered with the result and cleared on the out handshake.
- Not defined: out_trap is tied to 0 and no overflow logic is built.

Test Plan:
- addu: rs=0x00000005, rt=0x00000003 → alu_aluc=000000, out_result=0x00000008, out_valid at N+1.
- sra: shamt=4, rt=0x80000000 → alu_a=4, alu_aluc=001100, out_result=0xF8000000.
- MULTU: rs=0xFFFFFFFF, rt=0x00000002 → out_hi=0x00000001, out_lo=0xFFFFFFFE, out_valid at N+32, out_hilo_we=1. DIVU: rs=100, rt=7 → lo=14, hi=2. DIVU: rs=0x1234, rt=0 → lo=0xFFFFFFFF, hi=0x1234.
- lui imm=0xABCD → out_result=0xABCD0000. Illegal op=0x3F → out_illegal=1 at N+1, alu ports unchanged from the previous op.
- Backpressure: out_ready held 0 for 5 cycles → outputs stable, in_ready=0 throughout. rst_n pulsed low mid-DIVU → out_valid=0, IDLE, no result emitted.
- ALU_TRAP_EN: add rs=0x7FFFFFFF, rt=1 → out_trap=1. addu with the same operands → out_trap=0.
